dbg_jtag_host: RTL

- Host-side driver for the Nios II debug slave's virtual JTAG interface.
- Runs in the system clock domain and generates the vji_* signals in place of the sld_virtual_jtag_basic hub: tck, tdi, ir_in and the virtual state strobes.
- Takes a command containing a 2-bit IR and a 38-bit DR, then runs UIR → CDR → SDR → UDR → RTI.
- Returns the 38-bit DR captured from tdo plus ir_out. Used for on-chip self-test of the debug path and for bench-driving the debug slave.

---
 rtl/dbg_jtag_host.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/dbg_jtag_host.sv
// Host-side virtual JTAG driver: generates tck/tdi/ir_in and UIR/CDR/SDR/UDR/RTI strobes for the debug slave.
// Latency: cmd handshake to rsp_valid = (DR_WIDTH+4)*2*TCK_HALF + 1 clk; one tick fewer when UIR is skipped.
// Backpressure: cmd_ready only in IDLE; the response is held stable in RSP until rsp_ready.
// Optional: define DBG_JTAG_HOST_IR_CACHE_EN to skip UIR when the new IR equals the one already loaded.
module dbg_jtag_host #(
  parameter int DR_WIDTH = 38,
  parameter int IR_WIDTH = 2,
  parameter int TCK_HALF = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_dr,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_dr,
  output logic [IR_WIDTH-1:0] rsp_ir_out,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  input  logic [IR_WIDTH-1:0] vji_ir_out,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti
);

  localparam int TW = $clog2(2 * TCK_HALF);
  localparam int CW = $clog2(DR_WIDTH + 1);
  localparam logic [TW-1:0] T_HALF = TW'(TCK_HALF);
  localparam logic [TW-1:0] T_LAST = TW'(2 * TCK_HALF - 1);
  localparam logic [CW-1:0] C_LAST = CW'(DR_WIDTH - 1);
  // With a one-cycle half period the shift and the tick boundary share an edge.
  localparam bit RISE_AT_END = (TCK_HALF == 1);

  typedef enum logic [2:0] {
    S_IDLE, S_UIR, S_CDR, S_SDR, S_UDR, S_RTI, S_RSP
  } state_t;

  state_t state, state_nxt;

  logic [TW-1:0]       tcnt;
  logic [CW-1:0]       bcnt;
  logic [DR_WIDTH-1:0] sr;
  logic [DR_WIDTH-1:0] sr_shift;
  logic                tdi_q;
  logic                tdi_next;
  logic                busy;
  logic                tick_end;
  logic                tck_rise;
  logic                skip_uir;

  assign busy     = (state != S_IDLE) && (state != S_RSP);
  assign tick_end = (tcnt == T_LAST);
  assign tck_rise = (tcnt == T_HALF);
  assign sr_shift = {vji_tdo, sr[DR_WIDTH-1:1]};
  assign tdi_next = RISE_AT_END ? sr_shift[0] : sr[0];
  assign vji_tdi  = tdi_q;

`ifdef DBG_JTAG_HOST_IR_CACHE_EN
  logic ir_vld;
  assign skip_uir = ir_vld && (cmd_ir == vji_ir_in);
`else
  assign skip_uir = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode plus strobe, tck and handshake outputs, all derived from the state.
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    vji_uir   = 1'b0;
    vji_cdr   = 1'b0;
    vji_sdr   = 1'b0;
    vji_udr   = 1'b0;
    vji_rti   = 1'b0;
    vji_tck   = busy && (tcnt >= T_HALF);
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = skip_uir ? S_CDR : S_UIR;
      end
      S_UIR: begin
        vji_uir = 1'b1;
        if (tick_end) state_nxt = S_CDR;
      end
      S_CDR: begin
        vji_cdr = 1'b1;
        if (tick_end) state_nxt = S_SDR;
      end
      S_SDR: begin
        vji_sdr = 1'b1;
        if (tick_end && (bcnt == C_LAST)) state_nxt = S_UDR;
      end
      S_UDR: begin
        vji_udr = 1'b1;
        if (tick_end) state_nxt = S_RTI;
      end
      S_RTI: begin
        vji_rti = 1'b1;
        if (tick_end) state_nxt = S_RSP;
      end
      S_RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Tick counter, shift register, tdi and response capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt       <= '0;
      bcnt       <= '0;
      sr         <= '0;
      tdi_q      <= 1'b0;
      vji_ir_in  <= '0;
      rsp_dr     <= '0;
      rsp_ir_out <= '0;
`ifdef DBG_JTAG_HOST_IR_CACHE_EN
      ir_vld     <= 1'b0;
`endif
    end else begin
      if (busy) tcnt <= tick_end ? '0 : tcnt + TW'(1);
      else      tcnt <= '0;

      if ((state == S_IDLE) && cmd_valid) begin
        vji_ir_in <= cmd_ir;
        sr        <= cmd_dr;
        bcnt      <= '0;
`ifdef DBG_JTAG_HOST_IR_CACHE_EN
        ir_vld    <= 1'b1;
`endif
      end

      if ((state == S_CDR) && tck_rise) rsp_ir_out <= vji_ir_out;
      // First tdi bit is presented for the whole of the first SDR tick.
      if ((state == S_CDR) && tick_end) tdi_q <= sr[0];

      if ((state == S_SDR) && tck_rise) sr <= sr_shift;
      if ((state == S_SDR) && tick_end) begin
        bcnt  <= bcnt + CW'(1);
        tdi_q <= (bcnt == C_LAST) ? 1'b0 : tdi_next;
      end

      if ((state == S_RTI) && tick_end) rsp_dr <= sr;
    end
  end

endmodule
